// File: rtl/lade_speicher_einheit.sv
// Load/store unit: one word-addressed bus access per request, aligned/extended loads, lane-steered stores.
// Latency: done pulse 2+ cycles after request (1 when misaligned); waits on MemBereit, then on request release.
module lade_speicher_einheit (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        LoadDatenSignal,
   input  logic        StoreDatenSignal,
   input  logic [31:0] Adresse,
   input  logic [31:0] SchreibDaten,
   input  logic [2:0]  Funct3,
   output logic [31:0] LadeDaten,
   output logic        DatenGeladen,
   output logic        DatenGespeichert,
   output logic        Fehlausrichtung,
   output logic [31:0] MemAdresse,
   output logic [31:0] MemSchreibDaten,
   output logic [3:0]  MemByteEnable,
   output logic        MemLesen,
   output logic        MemSchreiben,
   input  logic        MemBereit,
   input  logic [31:0] MemLeseDaten
);

   typedef enum logic [1:0] {
      IDLE,
      ZUGRIFF,
      FERTIG,
      FREIGABE
   } zustandTyp;

   zustandTyp zustand;
   zustandTyp naechsterZustand;

   logic        istLoad;
   logic [1:0]  versatz;
   logic [2:0]  breiteReg;

   logic        annehmen;
   logic        ladeNext;
   logic        istByte;
   logic        istHalb;
   logic        fehlAktuell;
   logic [31:0] steerDaten;
   logic [3:0]  steerEnable;
   logic [31:0] geschoben;
   logic [31:0] erweitert;
   logic        lesenNext;
   logic        schreibenNext;
   logic        geladenNext;
   logic        gespeichertNext;
   logic        fehlNext;

   // Funct3[1:0] alone selects the width; every encoding other than byte/half is a word.
   always_comb begin
      istByte     = (Funct3[1:0] == 2'b00);
      istHalb     = (Funct3[1:0] == 2'b01);
      fehlAktuell = (istHalb & Adresse[0]) | (~istByte & ~istHalb & (|Adresse[1:0]));
   end

   always_comb begin
      steerDaten  = SchreibDaten;
      steerEnable = 4'b1111;
      if (LoadDatenSignal) begin
         steerEnable = 4'b0000;
      end else if (istByte) begin
         steerDaten  = {4{SchreibDaten[7:0]}};
         steerEnable = 4'b0001 << Adresse[1:0];
      end else if (istHalb) begin
         steerDaten  = {2{SchreibDaten[15:0]}};
         steerEnable = Adresse[1] ? 4'b1100 : 4'b0011;
      end
   end

   // Extraction uses the latched offset/width, since the request inputs may change meanwhile.
   always_comb begin
      geschoben = MemLeseDaten >> {versatz, 3'b000};
      case (breiteReg)
         3'b000:  erweitert = {{24{geschoben[7]}}, geschoben[7:0]};
         3'b100:  erweitert = {24'd0, geschoben[7:0]};
         3'b001:  erweitert = {{16{geschoben[15]}}, geschoben[15:0]};
         3'b101:  erweitert = {16'd0, geschoben[15:0]};
         default: erweitert = geschoben;
      endcase
   end

   always_comb begin
      naechsterZustand = zustand;
      annehmen         = 1'b0;
      case (zustand)
         IDLE: begin
            if (LoadDatenSignal || StoreDatenSignal) begin
               annehmen         = 1'b1;
               naechsterZustand = fehlAktuell ? FERTIG : ZUGRIFF;
            end
         end
         ZUGRIFF: begin
            if (MemBereit) begin
               naechsterZustand = FERTIG;
            end
         end
         FERTIG: begin
            naechsterZustand = FREIGABE;
         end
         FREIGABE: begin
            if (!LoadDatenSignal && !StoreDatenSignal) begin
               naechsterZustand = IDLE;
            end
         end
         default: begin
            naechsterZustand = IDLE;
         end
      endcase
   end

   // All bus/done outputs are flops fed from the next-state decision.
   always_comb begin
      ladeNext        = annehmen ? LoadDatenSignal : istLoad;
      lesenNext       = (naechsterZustand == ZUGRIFF) & ladeNext;
      schreibenNext   = (naechsterZustand == ZUGRIFF) & ~ladeNext;
      geladenNext     = (naechsterZustand == FERTIG) & ladeNext;
      gespeichertNext = (naechsterZustand == FERTIG) & ~ladeNext;
      fehlNext        = annehmen & fehlAktuell;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         zustand          <= IDLE;
         istLoad          <= 1'b0;
         versatz          <= 2'b00;
         breiteReg        <= 3'b000;
         LadeDaten        <= 32'd0;
         DatenGeladen     <= 1'b0;
         DatenGespeichert <= 1'b0;
         Fehlausrichtung  <= 1'b0;
         MemAdresse       <= 32'd0;
         MemSchreibDaten  <= 32'd0;
         MemByteEnable    <= 4'b0000;
         MemLesen         <= 1'b0;
         MemSchreiben     <= 1'b0;
      end else begin
         zustand          <= naechsterZustand;
         DatenGeladen     <= geladenNext;
         DatenGespeichert <= gespeichertNext;
         Fehlausrichtung  <= fehlNext;
         MemLesen         <= lesenNext;
         MemSchreiben     <= schreibenNext;
         if (annehmen) begin
            istLoad         <= LoadDatenSignal;
            versatz         <= Adresse[1:0];
            breiteReg       <= Funct3;
            MemAdresse      <= {Adresse[31:2], 2'b00};
            MemSchreibDaten <= steerDaten;
            MemByteEnable   <= steerEnable;
         end
         if (annehmen && LoadDatenSignal && fehlAktuell) begin
            LadeDaten <= 32'd0;
         end else if ((zustand == ZUGRIFF) && MemBereit && istLoad) begin
            LadeDaten <= erweitert;
         end
      end
   end

endmodule

// File: tb/tb_lade_speicher_einheit.sv
// Bench for lade_speicher_einheit: scripted per-cycle expectations from a transaction-level model.
module tb_lade_speicher_einheit;

   logic        Clock;
   logic        Reset;
   logic        LoadDatenSignal;
   logic        StoreDatenSignal;
   logic [31:0] Adresse;
   logic [31:0] SchreibDaten;
   logic [2:0]  Funct3;
   logic [31:0] LadeDaten;
   logic        DatenGeladen;
   logic        DatenGespeichert;
   logic        Fehlausrichtung;
   logic [31:0] MemAdresse;
   logic [31:0] MemSchreibDaten;
   logic [3:0]  MemByteEnable;
   logic        MemLesen;
   logic        MemSchreiben;
   logic        MemBereit;
   logic [31:0] MemLeseDaten;

   lade_speicher_einheit dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .LoadDatenSignal (LoadDatenSignal),
      .StoreDatenSignal(StoreDatenSignal),
      .Adresse         (Adresse),
      .SchreibDaten    (SchreibDaten),
      .Funct3          (Funct3),
      .LadeDaten       (LadeDaten),
      .DatenGeladen    (DatenGeladen),
      .DatenGespeichert(DatenGespeichert),
      .Fehlausrichtung (Fehlausrichtung),
      .MemAdresse      (MemAdresse),
      .MemSchreibDaten (MemSchreibDaten),
      .MemByteEnable   (MemByteEnable),
      .MemLesen        (MemLesen),
      .MemSchreiben    (MemSchreiben),
      .MemBereit       (MemBereit),
      .MemLeseDaten    (MemLeseDaten)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int tests = 0;
   int fails = 0;
   int pulse = 0;
   int nTx   = 0;

   bit          pruefen = 1'b0;
   bit          eLesen, eSchreiben, eGeladen, eGespeichert, eFehl;
   bit          eBusChk, eWdChk;
   logic [31:0] eLade, eAdr, eWd;
   logic [3:0]  eBe;
   logic [31:0] lastLade = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      if (pruefen) begin
         chk("MemLesen", {31'd0, MemLesen}, {31'd0, eLesen});
         chk("MemSchreiben", {31'd0, MemSchreiben}, {31'd0, eSchreiben});
         chk("DatenGeladen", {31'd0, DatenGeladen}, {31'd0, eGeladen});
         chk("DatenGespeichert", {31'd0, DatenGespeichert}, {31'd0, eGespeichert});
         chk("Fehlausrichtung", {31'd0, Fehlausrichtung}, {31'd0, eFehl});
         chk("LadeDaten", LadeDaten, eLade);
         if (eBusChk) begin
            chk("MemAdresse", MemAdresse, eAdr);
            chk("MemByteEnable", {28'd0, MemByteEnable}, {28'd0, eBe});
         end
         if (eWdChk) chk("MemSchreibDaten", MemSchreibDaten, eWd);
         if (DatenGeladen || DatenGespeichert) pulse++;
      end
   end

   // Transaction-level model straight from the access rules.
   task automatic modell(input bit ld, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [2:0] f3, input logic [31:0] wort,
                         output bit mis, output logic [3:0] be, output logic [31:0] wdo,
                         output logic [31:0] res);
      bit isByte, isHalf, isWord;
      logic [31:0] sh;
      isByte = (f3 == 3'd0) || (f3 == 3'd4);
      isHalf = (f3 == 3'd1) || (f3 == 3'd5);
      isWord = !isByte && !isHalf;
      mis = (isHalf && adr[0]) || (isWord && adr[1:0] != 2'b00);
      wdo = wd;
      be  = 4'hF;
      if (ld) be = 4'h0;
      else if (isByte) begin
         wdo = {4{wd[7:0]}};
         be  = 4'b0001 << adr[1:0];
      end else if (isHalf) begin
         wdo = {2{wd[15:0]}};
         be  = adr[1] ? 4'b1100 : 4'b0011;
      end
      sh = wort >> (8 * int'(adr[1:0]));
      case (f3)
         3'd0:    res = {{24{sh[7]}}, sh[7:0]};
         3'd4:    res = {24'd0, sh[7:0]};
         3'd1:    res = {{16{sh[15]}}, sh[15:0]};
         3'd5:    res = {16'd0, sh[15:0]};
         default: res = sh;
      endcase
      if (mis) res = 32'd0;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic ruhe();
      eLesen = 0; eSchreiben = 0; eGeladen = 0; eGespeichert = 0; eFehl = 0;
      eBusChk = 0; eWdChk = 0;
      eLade = lastLade;
   endtask

   task automatic stoeren();
      Adresse      = $urandom;
      SchreibDaten = $urandom;
      Funct3       = 3'($urandom_range(0, 7));
      MemLeseDaten = $urandom;
   endtask

   task automatic transaktion(input bit ld, input bit st, input logic [31:0] adr,
                              input logic [31:0] wd, input logic [2:0] f3,
                              input logic [31:0] wort, input int nBus,
                              input int halten, input int pause);
      bit mis;
      logic [3:0] be;
      logic [31:0] wdo, res;
      modell(ld, adr, wd, f3, wort, mis, be, wdo, res);
      tick();
      LoadDatenSignal = ld; StoreDatenSignal = st;
      Adresse = adr; SchreibDaten = wd; Funct3 = f3;
      MemBereit = 1'($urandom_range(0, 1)); MemLeseDaten = $urandom;
      ruhe();
      if (!mis) begin
         for (int i = 0; i < nBus; i++) begin
            tick();
            stoeren();
            MemBereit = (i == nBus - 1);
            if (i == nBus - 1) MemLeseDaten = wort;
            ruhe();
            eLesen = ld; eSchreiben = !ld;
            eBusChk = 1; eAdr = {adr[31:2], 2'b00}; eBe = be;
            eWdChk = !ld; eWd = wdo;
         end
      end
      tick();
      stoeren();
      MemBereit = 1'($urandom_range(0, 1));
      if (ld) lastLade = res;
      ruhe();
      eGeladen = ld; eGespeichert = !ld; eFehl = mis;
      nTx++;
      for (int i = 0; i < halten; i++) begin
         tick();
         stoeren();
         MemBereit = 1'($urandom_range(0, 1));
         ruhe();
      end
      tick();
      LoadDatenSignal = 0; StoreDatenSignal = 0;
      MemBereit = 1'($urandom_range(0, 1));
      ruhe();
      for (int i = 1; i < pause; i++) begin
         tick();
         ruhe();
      end
   endtask

   initial begin
      Reset = 1; LoadDatenSignal = 0; StoreDatenSignal = 0;
      Adresse = 0; SchreibDaten = 0; Funct3 = 0; MemBereit = 0; MemLeseDaten = 0;
      tick();
      ruhe();
      eBusChk = 1; eAdr = 0; eBe = 0; eWdChk = 1; eWd = 0;
      pruefen = 1;
      tick();
      Reset = 0;
      tick();
      ruhe();

      transaktion(1, 0, 32'h100, 32'h0, 3'd2, 32'hDEADBEEF, 1, 0, 2);
      chk("LW lit", LadeDaten, 32'hDEADBEEF);
      transaktion(1, 0, 32'h103, 32'h0, 3'd0, 32'h80FF0011, 1, 0, 1);
      chk("LB lit", LadeDaten, 32'hFFFFFF80);
      transaktion(1, 0, 32'h103, 32'h0, 3'd4, 32'h80FF0011, 2, 0, 1);
      chk("LBU lit", LadeDaten, 32'h00000080);
      transaktion(1, 0, 32'h102, 32'h0, 3'd1, 32'h80FF0011, 1, 1, 1);
      chk("LH lit", LadeDaten, 32'hFFFF80FF);
      transaktion(0, 1, 32'h201, 32'h000000A5, 3'd0, 32'h0, 3, 0, 1);
      chk("SB adr lit", MemAdresse, 32'h200);
      chk("SB be lit", {28'd0, MemByteEnable}, 32'h2);
      chk("SB data lit", MemSchreibDaten, 32'hA5A5A5A5);
      transaktion(1, 0, 32'h102, 32'h0, 3'd2, 32'h12345678, 1, 0, 1);
      chk("LW misaligned lit", LadeDaten, 32'h0);
      transaktion(0, 1, 32'h404, 32'hCAFEF00D, 3'd2, 32'h0, 1, 5, 1);
      transaktion(1, 1, 32'h40A, 32'h55555555, 3'd5, 32'hBEEF1234, 2, 2, 1);
      chk("LHU both-req lit", LadeDaten, 32'h0000BEEF);

      // Reset in the middle of a store bus access.
      tick();
      StoreDatenSignal = 1; Adresse = 32'h300; SchreibDaten = 32'h11223344; Funct3 = 3'd2;
      MemBereit = 0;
      ruhe();
      tick();
      stoeren(); MemBereit = 0;
      ruhe();
      eSchreiben = 1; eBusChk = 1; eAdr = 32'h300; eBe = 4'hF; eWdChk = 1; eWd = 32'h11223344;
      tick();
      Reset = 1; StoreDatenSignal = 0; MemBereit = 1;
      tick();
      Reset = 0; MemBereit = 0;
      lastLade = 0;
      ruhe();
      eBusChk = 1; eAdr = 0; eBe = 0; eWdChk = 1; eWd = 0;
      tick();
      ruhe();
      transaktion(1, 0, 32'h500, 32'h0, 3'd2, 32'h0BADF00D, 2, 0, 1);
      chk("LW after reset lit", LadeDaten, 32'h0BADF00D);

      for (int n = 0; n < 150; n++) begin
         bit ld, st;
         ld = 1'($urandom_range(0, 1));
         st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
         transaktion(ld, st, $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom,
                     $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(1, 2));
      end

      tick();
      chk("done pulse count", pulse, nTx);
      pruefen = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lade_speicher_einheit.md
# lade_speicher_einheit

Load/store unit directly downstream of the processor control FSM. It accepts the level requests `LoadDatenSignal`/`StoreDatenSignal` raised in the writeback load/store states, performs one word-addressed memory bus transaction, and returns single-cycle `DatenGeladen`/`DatenGespeichert` pulses. Load data is aligned and sign/zero-extended and held stable for the register write in the following writeback state. Stores get byte-lane steering and byte enables.

## Interface
Parameters: none; address and data widths are fixed at 32.

- Clock  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- LoadDatenSignal  in  1  load request, level; held by the controller until `DatenGeladen`.
- StoreDatenSignal  in  1  store request, level; held until `DatenGespeichert`.
- Adresse  in  32  byte address computed by the ALU.
- SchreibDaten  in  32  store source register value.
- Funct3  in  3  access width: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; any other value is treated as a word access.
- LadeDaten  out  32  extended load result, registered.
- DatenGeladen  out  1  one-cycle pulse, load complete.
- DatenGespeichert  out  1  one-cycle pulse, store complete.
- Fehlausrichtung  out  1  high together with the done pulse when the access was misaligned.
- MemAdresse  out  32  word address, i.e. `{Adresse[31:2],2'b00}`; registered.
- MemSchreibDaten  out  32  lane-steered store data; registered.
- MemByteEnable  out  4  store byte enables; 0000 for loads.
- MemLesen / MemSchreiben  out  1  bus read / write request, registered.
- MemBereit  in  1  bus acknowledge; `MemLeseDaten` is valid in the same cycle.
- MemLeseDaten  in  32  read word from the bus.

## Operation
- States: IDLE, ZUGRIFF, FERTIG, FREIGABE.
- IDLE: when `LoadDatenSignal` or `StoreDatenSignal` is sampled high:
  - Latch `Adresse[1:0]`, `Funct3`, the request type, `MemAdresse` and `MemSchreibDaten`/`MemByteEnable`.
  - Load has priority if both requests are high; the store is dropped.
  - Aligned access -> ZUGRIFF. Misaligned access -> FERTIG with no bus access.
- Misaligned means: halfword with `Adresse[0]`=1, or word with `Adresse[1:0]`≠00.
- ZUGRIFF:
  - `MemLesen` (load) or `MemSchreiben` (store) is high for every cycle spent in this state.
  - On `MemBereit`=1: capture the extended load result into `LadeDaten` and go to FERTIG.
- FERTIG: exactly one cycle.
  - Pulse `DatenGeladen` or `DatenGespeichert` according to the request type.
  - `Fehlausrichtung` is high in this cycle if the access was misaligned; a misaligned load also sets `LadeDaten`=0.
  - Always -> FREIGABE.
- FREIGABE: stay until both requests are low, then -> IDLE. This makes it impossible to retrigger on a request that is still held.
- Store lane steering:
  - SB: data `{4{SchreibDaten[7:0]}}`, enable `0001<<Adresse[1:0]`.
  - SH: data `{2{SchreibDaten[15:0]}}`, enable 0011 if `Adresse[1]`=0, else 1100.
  - SW: data unchanged, enable 1111.
- Load extraction: shift `MemLeseDaten` right by `8*Adresse[1:0]`.
  - LB/LH: sign-extend bit 7 / bit 15.
  - LBU/LHU: zero-extend.
  - LW: the word unchanged.
- `LadeDaten` holds its value until the next load is captured.
- `MemBereit` is ignored outside ZUGRIFF.

## Timing
- Reset: state IDLE. All outputs are 0: `LadeDaten`, `DatenGeladen`, `DatenGespeichert`, `Fehlausrichtung`, `MemLesen`, `MemSchreiben`, `MemByteEnable`, `MemAdresse`, `MemSchreibDaten`.
- Reset mid-access: the bus request drops in the cycle after Reset is sampled and no done pulse is issued. The bus side must tolerate an abandoned request.
- Request path:
  - Request seen in IDLE at cycle 0 -> `MemLesen`/`MemSchreiben` high from cycle 1.
  - `MemBereit` at cycle k≥1 -> done pulse at cycle k+1, with the request deasserted in that same cycle.
  - Minimum latency from request to done pulse is 2 cycles.
- Misaligned path: request at cycle 0 -> done pulse plus `Fehlausrichtung` at cycle 1; no bus activity.
- `LadeDaten` is valid in the done-pulse cycle and after it, which covers the controller's register-write state.
- The next request is accepted no earlier than one cycle after the request drops (FREIGABE -> IDLE -> accept).

## Test plan
- LW at 0x100; bus returns 0xDEADBEEF with `MemBereit` in the first ZUGRIFF cycle.
  - `MemLesen`=1 only at cycle 1; `DatenGeladen` pulses one cycle at cycle 2.
  - `LadeDaten`=0xDEADBEEF and stays after the request drops.
- LB at 0x103 and LBU at 0x103 with bus word 0x80FF0011 -> `LadeDaten`=0xFFFFFF80 and 0x00000080 respectively. LH at 0x102 -> 0xFFFF80FF.
- SB of 0x000000A5 at 0x201 -> `MemAdresse`=0x200, `MemByteEnable`=0010, `MemSchreibDaten`=0xA5A5A5A5.
  - `MemBereit` delayed 3 cycles -> `MemSchreiben` held 3 cycles, then `DatenGespeichert` pulses once.
- LW at 0x102 -> no `MemLesen`; at cycle 1 `DatenGeladen`=1, `Fehlausrichtung`=1, `LadeDaten`=0.
- Request held high for 5 cycles after the done pulse -> exactly one done pulse and no second bus access. The next request is accepted after the drop.
- Reset asserted while `MemSchreiben`=1 -> all outputs 0 on the next cycle, no `DatenGespeichert`. A following LW completes normally.
